// File: rtl/excitation_pkg.sv
// Shared constants, FSM state encoding and LFSR step function for the excitation source.
package excitation_pkg;

  localparam int unsigned LFSR_W     = 17;
  localparam int unsigned LFSR_TAP_A = 0;
  localparam int unsigned LFSR_TAP_B = 3;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 17'h1;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t PEND = 1'b1;

  // Fibonacci step: feedback enters at the MSB, the LSB is the output bit.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_TAP_A] ^ v[LFSR_TAP_B], v[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr17.sv
// 17-bit Fibonacci LFSR with advance enable; exposes the current LSB as the noise sign bit.
module lfsr17
  import excitation_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic adv_i,
  output logic bit_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/excitation_source.sv
// Voiced pulse-train / unvoiced noise excitation generator with valid/ack hand-off.
// Define SRC_OVERRUN_EN to build the sticky overrun flag; otherwise overrun is tied low.
module excitation_source
  import excitation_pkg::*;
#(
  parameter int unsigned       AMP_SHIFT = 6,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       param_load,
  input  logic [7:0]                 period_in,
  input  logic [7:0]                 amp_in,
  output logic signed [SAMPLE_W-1:0] src_out,
  output logic                       src_valid,
  input  logic                       src_ack,
  output logic                       overrun
);

  if (AMP_SHIFT > 7) begin : g_bad_shift
    $error("AMP_SHIFT must be <= 7 so the magnitude fits in 15 bits");
  end

  logic [7:0]                 period_q, period_d;
  logic [7:0]                 amp_q, amp_d;
  logic [7:0]                 pcnt_q, pcnt_d;
  state_t                     state_q, state_d;
  logic signed [SAMPLE_W-1:0] src_out_q, src_out_d;

  logic                       noise_bit;
  logic [SAMPLE_W-2:0]        mag;
  logic signed [SAMPLE_W-1:0] pos_s, sample;
  logic                       voiced;

  lfsr17 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv_i (tick),
    .bit_o (noise_bit)
  );

  assign mag    = (SAMPLE_W-1)'(amp_q) << AMP_SHIFT;
  assign pos_s  = signed'({1'b0, mag});
  assign voiced = (period_q != 8'd0);

  always_comb begin
    if (voiced) sample = (pcnt_q == 8'd0) ? pos_s : '0;
    else        sample = noise_bit ? pos_s : -pos_s;
  end

  always_comb begin
    period_d  = period_q;
    amp_d     = amp_q;
    pcnt_d    = pcnt_q;
    state_d   = state_q;
    src_out_d = src_out_q;

    // Tick sees the pre-load parameters; a same-cycle load only affects later ticks.
    if (tick) begin
      if (voiced) pcnt_d = (pcnt_q >= period_q - 8'd1) ? 8'd0 : pcnt_q + 8'd1;
      src_out_d = sample;
      state_d   = PEND;
    end else if (src_ack && state_q == PEND) begin
      state_d = IDLE;
    end

    if (param_load) begin
      period_d = period_in;
      amp_d    = amp_in;
      if (!voiced && period_in != 8'd0) pcnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q  <= 8'd0;
      amp_q     <= 8'd0;
      pcnt_q    <= 8'd0;
      state_q   <= IDLE;
      src_out_q <= '0;
    end else begin
      period_q  <= period_d;
      amp_q     <= amp_d;
      pcnt_q    <= pcnt_d;
      state_q   <= state_d;
      src_out_q <= src_out_d;
    end
  end

  assign src_out   = src_out_q;
  assign src_valid = (state_q == PEND);

`ifdef SRC_OVERRUN_EN
  logic overrun_q, overrun_d;

  assign overrun_d = overrun_q | (tick & (state_q == PEND) & ~src_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_excitation_source.sv
// Randomised and directed bench for excitation_source against a behavioural sample model.
module tb_excitation_source;

`ifdef SRC_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  localparam int SHIFT = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tick = 1'b0;
  logic               param_load = 1'b0;
  logic [7:0]         period_in = 8'd0;
  logic [7:0]         amp_in = 8'd0;
  logic signed [15:0] src_out;
  logic               src_valid;
  logic               src_ack = 1'b0;
  logic               overrun;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int          m_period, m_amp, m_pcnt, m_out;
  int unsigned m_lfsr;
  bit          m_pend, m_ovr;

  excitation_source dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .param_load (param_load),
    .period_in  (period_in),
    .amp_in     (amp_in),
    .src_out    (src_out),
    .src_valid  (src_valid),
    .src_ack    (src_ack),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_period = 0; m_amp = 0; m_pcnt = 0; m_out = 0;
    m_lfsr = 17'h1; m_pend = 0; m_ovr = 0;
  endtask

  task automatic model_edge(input bit t, input bit ld, input int p, input int a, input bit ack);
    int mag;
    mag = m_amp * (1 << SHIFT);
    if (t) begin
      if (m_period != 0) begin
        m_out  = (m_pcnt == 0) ? mag : 0;
        m_pcnt = (m_pcnt >= m_period - 1) ? 0 : m_pcnt + 1;
      end else begin
        m_out = (m_lfsr % 2 == 1) ? mag : -mag;
      end
      m_lfsr = (m_lfsr / 2) + ((((m_lfsr % 2) + ((m_lfsr / 8) % 2)) % 2) * 65536);
      if (m_pend && !ack) m_ovr = 1;
      m_pend = 1;
    end else if (ack) begin
      m_pend = 0;
    end
    if (ld) begin
      if (m_period == 0 && p != 0) m_pcnt = 0;
      m_period = p;
      m_amp    = a;
    end
  endtask

  task automatic cyc(input bit t, input bit ld, input int p, input int a, input bit ack);
    tick = t; param_load = ld; period_in = 8'(p); amp_in = 8'(a); src_ack = ack;
    model_edge(t, ld, p, a, ack);
    @(posedge clk); #1;
    tick = 0; param_load = 0; src_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; src_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (src_out !== 16'sd0 || src_valid !== 1'b0 || overrun !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: out=%0d valid=%b ovr=%b, want 0/0/0", i, src_out, src_valid,
                 overrun);
      end
    end
    tick = 1'b0; rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (src_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: valid=%b want 0", src_valid);
    end
  endtask

  task automatic test_voiced();
    int exp_pat[8] = '{6400, 0, 0, 0, 6400, 0, 0, 0};
    cyc(0, 1, 4, 100, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 0);
      checks++;
      if (src_valid !== 1'b1 || src_out !== 16'(exp_pat[i]) || src_out !== 16'(m_out)) begin
        failures++;
        $display("FAIL voiced[%0d]: out=%0d valid=%b, want %0d/1", i, src_out, src_valid,
                 exp_pat[i]);
      end
      cyc(0, 0, 0, 0, 1);
      checks++;
      if (src_valid !== 1'b0) begin
        failures++;
        $display("FAIL voiced_ack[%0d]: valid=%b want 0", i, src_valid);
      end
    end
  endtask

  task automatic test_noise();
    do_reset();
    cyc(0, 1, 0, 100, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (src_out !== 16'sd6400 || src_valid !== 1'b1) begin
      failures++;
      $display("FAIL noise_first: out=%0d valid=%b, want 6400/1", src_out, src_valid);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (src_out !== -16'sd6400 || src_out !== 16'(m_out)) begin
      failures++;
      $display("FAIL noise_second: out=%0d, want -6400", src_out);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_mode_switch();
    int exp_pat[4] = '{6400, 0, 0, 6400};
    // Load lands on a tick edge: that tick is still noise.
    cyc(1, 1, 3, 100, 0);
    checks++;
    if (src_out !== 16'(m_out) || (src_out !== 16'sd6400 && src_out !== -16'sd6400)) begin
      failures++;
      $display("FAIL switch_same_edge: out=%0d, want %0d", src_out, m_out);
    end
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0);
      checks++;
      if (src_out !== 16'(exp_pat[i])) begin
        failures++;
        $display("FAIL switch_voiced[%0d]: out=%0d, want %0d", i, src_out, exp_pat[i]);
      end
      cyc(0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    cyc(0, 1, 2, 50, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    checks++;
    if (src_valid !== 1'b1 || overrun !== 1'b0 || src_out !== 16'sd0) begin
      failures++;
      $display("FAIL tick_with_ack: valid=%b ovr=%b out=%0d, want 1/0/0", src_valid, overrun,
               src_out);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (src_valid !== 1'b1 || src_out !== 16'sd0 || overrun !== OVR_EN) begin
      failures++;
      $display("FAIL overrun: valid=%b out=%0d ovr=%b, want 1/0/%b", src_valid, src_out, overrun,
               OVR_EN);
    end
    cyc(0, 0, 0, 0, 1);
    checks++;
    if (src_valid !== 1'b0 || overrun !== OVR_EN) begin
      failures++;
      $display("FAIL overrun_sticky: valid=%b ovr=%b, want 0/%b", src_valid, overrun, OVR_EN);
    end
  endtask

  task automatic test_random();
    bit t, ld, ack;
    int p, a;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      t   = ($urandom_range(0, 1) == 1);
      ack = ($urandom_range(0, 2) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      p   = $urandom_range(0, 6);
      a   = $urandom_range(0, 255);
      cyc(t, ld, p, a, ack);
      checks++;
      if (src_valid !== m_pend || src_out !== 16'(m_out) || overrun !== (OVR_EN & m_ovr)) begin
        failures++;
        $display("FAIL random[%0d]: valid=%b out=%0d ovr=%b, want %b/%0d/%b", i, src_valid,
                 src_out, overrun, m_pend, m_out, OVR_EN & m_ovr);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 1, 0, 100, 1);
    cyc(1, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (src_valid !== 1'b0 || src_out !== 16'sd0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b out=%0d ovr=%b, want 0/0/0", src_valid, src_out,
               overrun);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    cyc(0, 1, 0, 100, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (src_out !== 16'sd6400) begin
      failures++;
      $display("FAIL seed_restart_1: out=%0d, want 6400", src_out);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (src_out !== -16'sd6400) begin
      failures++;
      $display("FAIL seed_restart_2: out=%0d, want -6400", src_out);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_voiced();
    test_noise();
    test_mode_switch();
    test_overrun();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
